pipe_wallace_mult: RTL and testbench

PIPE_WALLACE_MULT -- requirements
Module: pipe_wallace_mult

---
 rtl/pipe_wallace_mult.sv | 161 ++++++++++++++++
 tb/tb_pipe_wallace_mult.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_wallace_mult.sv
// pipe_wallace_mult: three-stage pipelined multiplier for signed or unsigned
// operands. Stage 1 forms partial-product rows, stage 2 reduces them to a
// sum/carry pair with a Wallace tree of 3:2 compressors, and stage 3 does the
// final carry-propagate add. One global advance signal stalls all stages.
// Bubbles are carried through the pipeline rather than collapsed.
module pipe_wallace_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out
);

    localparam int P = 2 * WIDTH;

    // 3:2 compressor, sum output
    function automatic logic [P-1:0] csa_sum(input logic [P-1:0] a,
                                             input logic [P-1:0] b,
                                             input logic [P-1:0] c);
        return a ^ b ^ c;
    endfunction

    // 3:2 compressor, carry output moved up one weight; the top carry is dropped
    function automatic logic [P-1:0] csa_carry(input logic [P-1:0] a,
                                               input logic [P-1:0] b,
                                               input logic [P-1:0] c);
        return ((a & b) | (a & c) | (b & c)) << 1;
    endfunction

    logic             advance_s;
    logic [P-1:0]     xe_s;
    logic [P-1:0]     pp_s [WIDTH];
    logic [P-1:0]     cur_s [WIDTH];
    logic [P-1:0]     nxt_s [WIDTH];
    logic [P-1:0]     red_sum_s;
    logic [P-1:0]     red_carry_s;
    logic             cin_s;
    logic [P-1:0]     cpa_s;
    int               n_s;
    int               m_s;

    // stage 1 registers
    logic             v1_r;
    logic             sg1_r;
    logic             ym1_r;
    logic [P-1:0]     pp_r [WIDTH];
    // stage 2 registers
    logic             v2_r;
    logic             sg2_r;
    logic             ym2_r;
    logic [P-1:0]     sum_r;
    logic [P-1:0]     carry_r;
    // stage 3 registers
    logic             v3_r;
    logic [P-1:0]     out_r;

    assign advance_s = !v3_r || out_ready;
    assign in_ready  = advance_s;
    assign out_valid = v3_r;
    assign out       = out_r;

    // Partial-product rows. In signed mode the multiplier MSB carries weight
    // -2^(W-1), so its row is the one's complement of the shifted multiplicand;
    // the missing +1 is added as the carry-in of the final adder.
    always_comb begin
        if (is_signed) begin
            xe_s = {{WIDTH{x[WIDTH-1]}}, x};
        end else begin
            xe_s = {{WIDTH{1'b0}}, x};
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (y[i] && is_signed && (i == WIDTH - 1)) begin
                pp_s[i] = ~(xe_s << i);
            end else if (y[i]) begin
                pp_s[i] = xe_s << i;
            end else begin
                pp_s[i] = '0;
            end
        end
    end

    // Wallace reduction: each level compresses groups of three rows into two
    // until only a sum vector and a carry vector remain.
    always_comb begin
        n_s = WIDTH;
        m_s = 0;
        for (int k = 0; k < WIDTH; k++) begin
            cur_s[k] = pp_r[k];
            nxt_s[k] = '0;
        end
        for (int lvl = 0; lvl < WIDTH; lvl++) begin
            if (n_s > 2) begin
                m_s = 0;
                for (int g = 0; g < WIDTH; g++) begin
                    if (3 * g + 2 < n_s) begin
                        nxt_s[m_s]     = csa_sum(cur_s[3*g], cur_s[3*g+1], cur_s[3*g+2]);
                        nxt_s[m_s + 1] = csa_carry(cur_s[3*g], cur_s[3*g+1], cur_s[3*g+2]);
                        m_s = m_s + 2;
                    end else if (3 * g + 1 < n_s) begin
                        nxt_s[m_s]     = cur_s[3*g];
                        nxt_s[m_s + 1] = cur_s[3*g+1];
                        m_s = m_s + 2;
                    end else if (3 * g < n_s) begin
                        nxt_s[m_s] = cur_s[3*g];
                        m_s = m_s + 1;
                    end else begin
                        m_s = m_s;
                    end
                end
                cur_s = nxt_s;
                n_s   = m_s;
            end else begin
                n_s = n_s;
            end
        end
        red_sum_s   = cur_s[0];
        red_carry_s = cur_s[1];
    end

    // Final carry-propagate add, including the signed-mode correction bit
    always_comb begin
        cin_s = sg2_r & ym2_r;
        cpa_s = sum_r + carry_r + {{(P-1){1'b0}}, cin_s};
    end

    // Stage valid bits and the output register; cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_r  <= 1'b0;
            v2_r  <= 1'b0;
            v3_r  <= 1'b0;
            out_r <= '0;
        end else if (advance_s) begin
            v1_r  <= in_valid;
            v2_r  <= v1_r;
            v3_r  <= v2_r;
            out_r <= cpa_s;
        end
    end

    // Datapath registers of stages 1 and 2; contents are don't-care while invalid
    always_ff @(posedge clk) begin
        if (advance_s) begin
            pp_r    <= pp_s;
            sg1_r   <= is_signed;
            ym1_r   <= y[WIDTH-1];
            sum_r   <= red_sum_s;
            carry_r <= red_carry_s;
            sg2_r   <= sg1_r;
            ym2_r   <= ym1_r;
        end
    end

endmodule

// File: tb/tb_pipe_wallace_mult.sv
// Bench for pipe_wallace_mult: directed scenarios on an 8-bit instance and a
// randomized scoreboard run on a 16-bit instance.
module tb_pipe_wallace_mult;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        iv8, ir8, s8, ov8, or8;
    logic [7:0]  x8, y8;
    logic [15:0] out8;

    logic        iv16, ir16, s16, ov16, or16;
    logic [15:0] x16, y16;
    logic [31:0] out16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_wallace_mult #(.WIDTH(8)) u8 (
        .clk(clk), .reset_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .x(x8), .y(y8), .is_signed(s8), .out_valid(ov8), .out_ready(or8), .out(out8)
    );

    pipe_wallace_mult #(.WIDTH(16)) u16 (
        .clk(clk), .reset_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .x(x16), .y(y16), .is_signed(s16), .out_valid(ov16), .out_ready(or16), .out(out16)
    );

    // Reference product: interpret operands as integers, multiply, keep 2*w bits
    function automatic longint unsigned ref_prod(input longint unsigned a,
                                                 input longint unsigned b,
                                                 input bit s, input int w);
        longint sa;
        longint sb;
        longint unsigned p;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[w-1]) sa = sa - (longint'(1) << w);
        if (s && b[w-1]) sb = sb - (longint'(1) << w);
        p = longint'(sa * sb);
        return p & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        iv8 = 1'b0; x8 = 8'd0; y8 = 8'd0; s8 = 1'b0; or8 = 1'b1;
        iv16 = 1'b0; x16 = 16'd0; y16 = 16'd0; s16 = 1'b0; or16 = 1'b1;
        #1;
        checks++;
        if (ov8 !== 1'b0 || out8 !== 16'h0000 || ov16 !== 1'b0 || out16 !== 32'h0) begin
            errors++;
            $display("FAIL reset_state ov8=%b out8=%h ov16=%b out16=%h expected 0/0/0/0", ov8, out8, ov16, out16);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (ir8 !== 1'b1 || ir16 !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset ir8=%b ir16=%b expected 1/1", ir8, ir16);
        end
    endtask

    task automatic test_unsigned_max;
        @(negedge clk);
        x8 = 8'd255; y8 = 8'd255; s8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
        #1;
        checks++;
        if (ir8 !== 1'b1) begin
            errors++;
            $display("FAIL umax_in_ready got %b expected 1", ir8);
        end
        @(negedge clk);
        iv8 = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) @(negedge clk);
            checks++;
            if (c < 3 && ov8 !== 1'b0) begin
                errors++;
                $display("FAIL umax_latency cycle %0d out_valid=%b expected 0", c, ov8);
            end else if (c == 3 && (ov8 !== 1'b1 || out8 !== 16'hFE01)) begin
                errors++;
                $display("FAIL umax_product out_valid=%b out=%h expected 1/fe01", ov8, out8);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_signed;
        logic [7:0]  xs [3];
        logic [7:0]  ys [3];
        logic [15:0] es [3];
        xs[0] = 8'h80; ys[0] = 8'h80; es[0] = 16'h4000;
        xs[1] = 8'hFF; ys[1] = 8'h01; es[1] = 16'hFFFF;
        xs[2] = 8'h7F; ys[2] = 8'h80; es[2] = 16'hC080;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            x8 = xs[k]; y8 = ys[k]; s8 = 1'b1; iv8 = 1'b1; or8 = 1'b1;
            @(negedge clk);
            iv8 = 1'b0;
            @(negedge clk);
            checks++;
            if (ov8 !== 1'b0) begin
                errors++;
                $display("FAIL signed_early case %0d out_valid=%b expected 0", k, ov8);
            end
            @(negedge clk);
            checks++;
            if (ov8 !== 1'b1 || out8 !== es[k]) begin
                errors++;
                $display("FAIL signed_product case %0d out_valid=%b out=%h expected 1/%h", k, ov8, out8, es[k]);
            end
        end
        s8 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [7:0]  xs [3];
        logic [7:0]  ys [3];
        logic [15:0] es [3];
        xs[0] = 8'd3;   ys[0] = 8'd5; es[0] = 16'd15;
        xs[1] = 8'd0;   ys[1] = 8'd9; es[1] = 16'd0;
        xs[2] = 8'd200; ys[2] = 8'd2; es[2] = 16'd400;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            x8 = xs[k]; y8 = ys[k]; s8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            iv8 = 1'b0;
            checks++;
            if (ov8 !== 1'b1 || out8 !== es[k]) begin
                errors++;
                $display("FAIL b2b_product %0d out_valid=%b out=%0d expected 1/%0d", k, ov8, out8, es[k]);
            end
        end
        @(negedge clk);
        checks++;
        if (ov8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain out_valid=%b expected 0", ov8);
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] es [3];
        es[0] = 16'd77; es[1] = 16'd120; es[2] = 16'd2295;
        @(negedge clk); x8 = 8'd7;  y8 = 8'd11; s8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
        @(negedge clk); x8 = 8'd10; y8 = 8'd12;
        @(negedge clk); x8 = 8'd9;  y8 = 8'd255;
        @(negedge clk);
        iv8 = 1'b0; or8 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (ir8 !== 1'b0 || ov8 !== 1'b1 || out8 !== es[0]) begin
                errors++;
                $display("FAIL stall_hold cycle %0d in_ready=%b out_valid=%b out=%0d expected 0/1/%0d", c, ir8, ov8, out8, es[0]);
            end
        end
        or8 = 1'b1;
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (ov8 !== 1'b1 || out8 !== es[k]) begin
                errors++;
                $display("FAIL stall_release %0d out_valid=%b out=%0d expected 1/%0d", k, ov8, out8, es[k]);
            end
        end
        @(negedge clk);
        checks++;
        if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
            errors++;
            $display("FAIL stall_drain out_valid=%b in_ready=%b expected 0/1", ov8, ir8);
        end
    endtask

    task automatic test_reset_mid_op;
        @(negedge clk); x8 = 8'd13; y8 = 8'd17; s8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
        @(negedge clk); x8 = 8'd21; y8 = 8'd4;
        @(negedge clk); iv8 = 1'b0;
        @(negedge clk);
        checks++;
        if (ov8 !== 1'b1 || out8 !== 16'd221) begin
            errors++;
            $display("FAIL mid_first out_valid=%b out=%0d expected 1/221", ov8, out8);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov8 !== 1'b0 || out8 !== 16'h0000) begin
            errors++;
            $display("FAIL mid_async_clear out_valid=%b out=%h expected 0/0000", ov8, out8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
                errors++;
                $display("FAIL mid_stale cycle %0d out_valid=%b in_ready=%b expected 0/1", c, ov8, ir8);
            end
        end
        // first pair after reset still has the full three-cycle latency
        x8 = 8'd6; y8 = 8'd7; iv8 = 1'b1;
        @(negedge clk); iv8 = 1'b0;
        @(negedge clk);
        checks++;
        if (ov8 !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_early out_valid=%b expected 0", ov8);
        end
        @(negedge clk);
        checks++;
        if (ov8 !== 1'b1 || out8 !== 16'd42) begin
            errors++;
            $display("FAIL post_reset_product out_valid=%b out=%0d expected 1/42", ov8, out8);
        end
        @(negedge clk);
    endtask

    task automatic test_random16;
        longint unsigned q [$];
        longint unsigned exp_v;
        int accepted = 0;
        int cycles = 0;
        bit holding = 1'b0;
        logic [31:0] held = 32'h0;
        while ((accepted < 10000 || q.size() > 0) && cycles < 60000) begin
            @(negedge clk);
            cycles++;
            if (holding) begin
                checks++;
                if (ov16 !== 1'b1 || out16 !== held) begin
                    errors++;
                    $display("FAIL rand_stall_stable out_valid=%b out=%h expected 1/%h", ov16, out16, held);
                end
            end
            iv16 = (accepted < 10000) && ($urandom_range(0, 3) != 0);
            x16  = 16'($urandom);
            y16  = 16'($urandom);
            s16  = 1'($urandom_range(0, 1));
            or16 = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (ir16 !== (!ov16 || or16)) begin
                errors++;
                $display("FAIL rand_in_ready got %b with out_valid=%b out_ready=%b", ir16, ov16, or16);
            end
            if (ov16 === 1'b1 && or16) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious out=%h with no product outstanding", out16);
                end else begin
                    exp_v = q.pop_front();
                    if (out16 !== exp_v[31:0]) begin
                        errors++;
                        $display("FAIL rand_product got %h expected %h", out16, exp_v[31:0]);
                    end
                end
            end
            if (iv16 && ir16 === 1'b1) begin
                q.push_back(ref_prod(64'(x16), 64'(y16), s16, 16));
                accepted++;
            end
            holding = (ov16 === 1'b1) && !or16;
            held = out16;
        end
        iv16 = 1'b0;
        checks++;
        if (cycles >= 60000) begin
            errors++;
            $display("FAIL rand_budget accepted=%0d outstanding=%0d expected 10000/0", accepted, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_op();
        test_random16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
